// File: rtl/fadd_flow_ctrl_if.sv
// Handshake and adder-side signal bundle for fadd_flow_ctrl.
// The slave modport is the flow-control block; the master modport is its environment (producer, adder, consumer).
interface fadd_flow_ctrl_if #(
  parameter int AW = 2
);
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_a;
  logic [31:0]   in_b;
  logic          in_sub;
  logic [1:0]    in_rm;

  logic [31:0]   fa_a;
  logic [31:0]   fa_b;
  logic          fa_sub;
  logic [1:0]    fa_rm;
  logic          fa_e;
  logic [31:0]   fa_s;

  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_s;
  logic [AW:0]   occupancy;

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_rm, fa_s, out_ready,
    output in_ready, fa_a, fa_b, fa_sub, fa_rm, fa_e, out_valid, out_s, occupancy
  );

  modport master (
    output in_valid, in_a, in_b, in_sub, in_rm, fa_s, out_ready,
    input  in_ready, fa_a, fa_b, fa_sub, fa_rm, fa_e, out_valid, out_s, occupancy
  );
endinterface

// File: rtl/fadd_flow_ctrl.sv
// Valid/ready wrapper around a 3-stage float adder: tracks live stages,
// buffers sums in an in-order FIFO and stalls the adder via fa_e when the FIFO cannot take a result.
module fadd_flow_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic clk,
  input  logic clrn,
  fadd_flow_ctrl_if.slave io
);
  localparam int            DATA_W  = 32;
  localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic              vld_p1;
  logic              vld_p2;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [DATA_W-1:0] mem [DEPTH];

  logic pop;
  logic push;
  logic fa_e;
  logic accept;

  assign pop    = io.out_valid & io.out_ready;
  // A full FIFO still accepts a result in a cycle where the head leaves.
  assign push   = vld_p2 & ((count < FULL) | pop);
  assign fa_e   = ~vld_p2 | push;
  assign accept = io.in_valid & io.in_ready;

  assign io.in_ready  = clrn & fa_e;
  assign io.fa_e      = fa_e;
  assign io.fa_a      = io.in_a;
  assign io.fa_b      = io.in_b;
  assign io.fa_sub    = io.in_sub;
  assign io.fa_rm     = io.in_rm;

  assign io.out_valid = (count != '0);
  assign io.out_s     = mem[rd_ptr];
  assign io.occupancy = count;

  // Stage p1/p2: liveness of the align->cal and cal->norm adder registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (fa_e) begin
      vld_p1 <= accept;
      vld_p2 <= vld_p1;
    end
  end

  // Result FIFO control
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Result FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= io.fa_s;
  end
endmodule
